// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmit scheduler.
// Round-robin arbiter feeding a single 8N1-style serialiser paced by an external baud tick.
// The SYNC state waits for the next tick so the start bit always spans a full bit period.
module uart_tx_scheduler #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 req0_valid,
   input  logic [DATA_BITS-1:0] req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [DATA_BITS-1:0] req1_data,
   output logic                 req1_ready,
   output logic                 txd,
   output logic                 busy,
   output logic                 owner
);

   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StStart,
      StData,
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 owner_q, owner_d;
   logic                 last_grant_q, last_grant_d;
   logic                 txd_q, txd_d;
   logic                 winner;

   // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      winner = 1'b0;
      if (req0_valid && req1_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = req1_valid;
      end
   end

   // State register; reset overrides ticks and transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         shreg_q      <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         txd_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         shreg_q      <= shreg_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         txd_q        <= txd_d;
      end
   end

   // Next-state logic: handshake in IDLE, tick-paced progression through the frame.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      shreg_d      = shreg_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      case (state_q)
         StIdle: begin
            // tick is deliberately ignored here, even when it coincides with a transfer
            if (req0_ready || req1_ready) begin
               state_d      = StSync;
               idx_d        = '0;
               shreg_d      = req1_ready ? req1_data : req0_data;
               owner_d      = req1_ready;
               last_grant_d = req1_ready;
            end
         end
         StSync: begin
            if (tick) state_d = StStart;
         end
         StStart: begin
            if (tick) begin
               state_d = StData;
               idx_d   = '0;
            end
         end
         StData: begin
            if (tick) begin
               if (idx_q == IDX_LAST) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (tick) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs: readys gated by reset and IDLE; txd level chosen from the current state
   // and registered, so the line follows the state one cycle later.
   always_comb begin
      req0_ready = !rst && (state_q == StIdle) && req0_valid && !winner;
      req1_ready = !rst && (state_q == StIdle) && req1_valid && winner;
      busy       = (state_q != StIdle);
      case (state_q)
         StStart: txd_d = 1'b0;
         StData:  txd_d = shreg_q[idx_q];
         default: txd_d = 1'b1;
      endcase
   end

   assign txd   = txd_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: tick every 4 clk, per-cycle log of outputs sampled
// on the falling edge, frames checked sample by sample against hand-computed bit patterns.
module tb_uart_tx_scheduler;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       txd, busy, owner;

   uart_tx_scheduler #(.DATA_BITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .txd        (txd),
      .busy       (busy),
      .owner      (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int LOG_LEN = 2048;

   int n_checks = 0;
   int n_errs   = 0;

   logic txd_l  [0:LOG_LEN-1];
   logic busy_l [0:LOG_LEN-1];
   logic own_l  [0:LOG_LEN-1];
   logic r0_l   [0:LOG_LEN-1];
   logic r1_l   [0:LOG_LEN-1];
   int   n;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         g_who[$];
   int         g_at[$];
   logic [7:0] g_dat[$];

   logic tick_auto, man_tick, pulse1, r0_s, r1_s;
   int   tph;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: retire the handshake seen last cycle, drive inputs, sample on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (r0_s && q0.size() > 0) void'(q0.pop_front());
      if (r1_s && q1.size() > 0) void'(q1.pop_front());
      tick = tick_auto ? (tph == 3) : man_tick;
      tph  = (tph + 1) % 4;
      req0_valid = (q0.size() > 0);
      req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      req1_valid = (q1.size() > 0) || pulse1;
      req1_data  = (q1.size() > 0) ? q1[0] : 8'hC3;
      @(negedge clk);
      if (n >= LOG_LEN) begin
         $display("FAIL log_overflow: got %0d expected below %0d", n, LOG_LEN);
         $fatal(1);
      end
      txd_l[n]  = txd;
      busy_l[n] = busy;
      own_l[n]  = owner;
      r0_l[n]   = req0_ready;
      r1_l[n]   = req1_ready;
      r0_s = req0_ready && req0_valid;
      r1_s = req1_ready && req1_valid;
      if (r0_s) begin g_who.push_back(0); g_at.push_back(n); g_dat.push_back(req0_data); end
      if (r1_s) begin g_who.push_back(1); g_at.push_back(n); g_dat.push_back(req1_data); end
      n++;
   endtask

   task automatic do_reset();
      q0.delete();
      q1.delete();
      pulse1 = 1'b0;
      rst = 1'b1;
      step();
      step();
      check_eq("rst_txd", txd_l[n-1], 1);
      check_eq("rst_busy", busy_l[n-1], 0);
      check_eq("rst_owner", own_l[n-1], 0);
      check_eq("rst_readys", {r0_l[n-1], r1_l[n-1]}, 0);
      rst = 1'b0;
      g_who.delete();
      g_at.delete();
      g_dat.delete();
   endtask

   function automatic int find_fall(input int from);
      for (int i = from; i < n; i++) begin
         if (i > 0 && txd_l[i] === 1'b0 && txd_l[i-1] === 1'b1) return i;
      end
      return -1;
   endfunction

   // Each bit is 4 samples: start 0, LSB-first data, stop 1.
   task automatic check_frame(input int s, input logic [7:0] b, input string tag);
      logic e;
      check_eq({tag, "_start_found"}, (s >= 0), 1);
      if (s >= 0) begin
         for (int i = 0; i < 40; i++) begin
            if (i < 4) e = 1'b0;
            else if (i >= 36) e = 1'b1;
            else e = b[i/4 - 1];
            check_eq($sformatf("%s_s%0d", tag, i), txd_l[s+i], e);
         end
      end
   endtask

   function automatic int count_hi(input int which, input int from, input int to);
      int c = 0;
      for (int i = from; i < to; i++) begin
         if (which == 0 && r0_l[i] === 1'b1) c++;
         if (which == 1 && r1_l[i] === 1'b1) c++;
      end
      return c;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int m, s, s0, ri, i1;
      int         exp_who[4];
      logic [7:0] exp_dat[4];
      exp_who = '{0, 1, 0, 1};
      exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44};

      rst = 1'b1; tick = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
      tick_auto = 1'b1; man_tick = 1'b0; pulse1 = 1'b0; tph = 0; n = 0;
      r0_s = 1'b0; r1_s = 1'b0;

      // Single 0xA5 frame from req0
      do_reset();
      m = n;
      q0.push_back(8'hA5);
      repeat (60) step();
      check_eq("a5_ready_cycles", count_hi(0, m, n), 1);
      check_eq("a5_owner", own_l[n-1], 0);
      s = find_fall(m);
      check_frame(s, 8'hA5, "a5");
      if (s >= 0) begin
         check_eq("a5_busy_in_stop", busy_l[s+38], 1);
         check_eq("a5_busy_after", busy_l[s+39], 0);
      end

      // Both requesters: round-robin 0,1,0,1 with back-to-back frames
      do_reset();
      m = n;
      q0.push_back(8'h11); q0.push_back(8'h33);
      q1.push_back(8'h22); q1.push_back(8'h44);
      repeat (200) step();
      check_eq("rr_grant_count", g_who.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < g_who.size()) begin
            check_eq($sformatf("rr_who%0d", i), g_who[i], exp_who[i]);
            check_eq($sformatf("rr_dat%0d", i), g_dat[i], exp_dat[i]);
            check_eq($sformatf("rr_owner%0d", i), own_l[g_at[i]+1], exp_who[i]);
            s = find_fall(g_at[i]);
            check_frame(s, exp_dat[i], $sformatf("rr%0d", i));
            if (i > 0) begin
               check_eq($sformatf("rr_gap%0d", i), g_at[i] - g_at[i-1], 44);
               check_eq($sformatf("rr_first_idle%0d", i), busy_l[g_at[i]-1], 1);
            end
         end
      end
      if (g_at.size() >= 2) check_eq("rr_r1_in_frame0", count_hi(1, m, g_at[1]), 0);

      // Reset during DATA bit 3 of 0xFF, coinciding with a tick, req0 valid during reset
      do_reset();
      check_eq("rst_owner_after_rr", own_l[n-1], 0);
      q0.push_back(8'hFF);
      s0 = -1;
      for (int k = 0; k < 100; k++) begin
         step();
         if (s0 < 0 && txd_l[n-1] === 1'b0 && txd_l[n-2] === 1'b1) s0 = n - 1;
         if (s0 >= 0 && n - 1 == s0 + 18) break;
      end
      check_eq("ff_reached_bit3", (s0 >= 0 && n - 1 == s0 + 18), 1);
      check_eq("ff_busy_bit3", busy_l[n-1], 1);
      g_who.delete(); g_at.delete(); g_dat.delete();
      q0.push_back(8'h5A);
      rst = 1'b1;
      step();
      rst = 1'b0;
      ri = n - 1;
      check_eq("midrst_txd", txd_l[ri], 1);
      check_eq("midrst_busy", busy_l[ri], 0);
      check_eq("midrst_ready0", r0_l[ri], 0);
      repeat (60) step();
      check_eq("post_rst_grants", g_dat.size(), 1);
      if (g_dat.size() > 0) check_eq("post_rst_data", g_dat[0], 8'h5A);
      check_frame(find_fall(ri), 8'h5A, "post_rst");

      // Tick coinciding with the transfer is ignored; start bit still a full interval
      do_reset();
      tick_auto = 1'b0;
      man_tick  = 1'b1;
      q0.push_back(8'h3C);
      step();
      i1 = n - 1;
      check_eq("tt_ready", r0_l[i1], 1);
      check_eq("tt_tick", tick, 1);
      man_tick = 1'b0;
      step();
      check_eq("tt_sync_busy", busy_l[n-1], 1);
      check_eq("tt_sync_txd_a", txd_l[n-1], 1);
      step();
      check_eq("tt_sync_txd_b", txd_l[n-1], 1);
      tick_auto = 1'b1;
      tph = 3;
      repeat (50) step();
      s = find_fall(i1);
      check_eq("tt_start_pos", s, i1 + 5);
      check_frame(s, 8'h3C, "tt");

      // req1 pulse during req0 frame is never accepted
      do_reset();
      m = n;
      q0.push_back(8'h77);
      repeat (12) step();
      pulse1 = 1'b1;
      step();
      step();
      pulse1 = 1'b0;
      repeat (60) step();
      check_eq("pulse_r1_never", count_hi(1, m, n), 0);
      check_eq("pulse_grants", g_who.size(), 1);
      check_eq("pulse_idle_end", busy_l[n-1], 0);
      check_eq("pulse_txd_end", txd_l[n-1], 1);
      check_frame(find_fall(m), 8'h77, "pulse");

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
